// File: rtl/regfile_stream_if.sv
// Datapath and dump-stream bus for regfile_stream.
// master: datapath + memory-write sink; slave: the register file itself.
interface regfile_stream_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] src0;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] outa;
    logic [DATA_W-1:0] outb;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        output src0, src1, dst, we, data, dump_start, dump_ready,
        input  outa, outb, dump_busy, dump_valid, dump_addr, dump_data, dump_last
    );

    modport slave (
        input  src0, src1, dst, we, data, dump_start, dump_ready,
        output outa, outb, dump_busy, dump_valid, dump_addr, dump_data, dump_last
    );
endinterface

// File: rtl/regfile_stream.sv
// Register file: two async read ports, one sync write port, optional
// write-to-read bypass, and a dump engine that streams a contiguous
// (wrapping) window of registers over a valid/ready handshake.
module regfile_stream #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int BYPASS     = 1,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_COUNT = 9
) (
    input logic             clk,
    input logic             rst_n,
    regfile_stream_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(DUMP_BASE % DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX      = ADDR_W'(DUMP_COUNT - 1);
    localparam logic              FIRST_IS_LAST = (DUMP_COUNT == 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;
    logic [ADDR_W-1:0] next_addr;

    // Next register contents: the single write port
    always_comb begin
        regs_d = regs_q;
        if (bus.we) begin
            regs_d[bus.dst] = bus.data;
        end
    end

    // Register array storage, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous read ports with optional same-cycle write forwarding
    always_comb begin
        bus.outa = regs_q[bus.src0];
        bus.outb = regs_q[bus.src1];
        if (BYPASS != 0 && bus.we && bus.src0 == bus.dst) begin
            bus.outa = bus.data;
        end
        if (BYPASS != 0 && bus.we && bus.src1 == bus.dst) begin
            bus.outb = bus.data;
        end
    end

    assign next_addr = dump_addr_q + ADDR_W'(1);

    // Dump FSM next-state: beats are loaded from regs_d so a write landing
    // on the load edge is captured; a stalled beat is a held snapshot.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        dump_last_d = dump_last_q;
        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    dump_addr_d = BASE_ADDR;
                    dump_data_d = regs_d[BASE_ADDR];
                    dump_last_d = FIRST_IS_LAST;
                end
            end
            SEND: begin
                if (bus.dump_ready) begin
                    if (dump_last_q) begin
                        state_d     = IDLE;
                        dump_last_d = 1'b0;
                    end else begin
                        idx_d       = idx_q + ADDR_W'(1);
                        dump_addr_d = next_addr;
                        dump_data_d = regs_d[next_addr];
                        dump_last_d = (idx_q + ADDR_W'(1) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dump FSM state and beat registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            dump_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            dump_last_q <= dump_last_d;
        end
    end

    assign bus.dump_busy  = (state_q == SEND);
    assign bus.dump_valid = (state_q == SEND);
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_last  = dump_last_q;
endmodule

// File: tb/tb_regfile_stream.sv
// Directed bench for regfile_stream: three instances share one stimulus
// stream (d0 default, d1 without bypass, d2 with a wrapping 14..1 window).
module tb_regfile_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] src0, src1, dst;
    logic       we;
    logic [7:0] data;
    logic       dump_start, dump_ready;

    int n_cmp = 0;
    int n_err = 0;

    regfile_stream_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
    regfile_stream_if #(.DATA_W(8), .ADDR_W(4)) if1 ();
    regfile_stream_if #(.DATA_W(8), .ADDR_W(4)) if2 ();

    assign if0.src0 = src0; assign if0.src1 = src1; assign if0.dst = dst;
    assign if0.we = we; assign if0.data = data;
    assign if0.dump_start = dump_start; assign if0.dump_ready = dump_ready;
    assign if1.src0 = src0; assign if1.src1 = src1; assign if1.dst = dst;
    assign if1.we = we; assign if1.data = data;
    assign if1.dump_start = dump_start; assign if1.dump_ready = dump_ready;
    assign if2.src0 = src0; assign if2.src1 = src1; assign if2.dst = dst;
    assign if2.we = we; assign if2.data = data;
    assign if2.dump_start = dump_start; assign if2.dump_ready = dump_ready;

    regfile_stream #(.DATA_W(8), .ADDR_W(4), .BYPASS(1), .DUMP_BASE(0), .DUMP_COUNT(9))
        d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    regfile_stream #(.DATA_W(8), .ADDR_W(4), .BYPASS(0), .DUMP_BASE(0), .DUMP_COUNT(9))
        d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    regfile_stream #(.DATA_W(8), .ADDR_W(4), .BYPASS(1), .DUMP_BASE(14), .DUMP_COUNT(4))
        d2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; src0 = '0; src1 = '0; dst = '0; we = 1'b0; data = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // reset state
        chk("rst_busy",  32'(if0.dump_busy),  32'd0);
        chk("rst_valid", 32'(if0.dump_valid), 32'd0);
        chk("rst_last",  32'(if0.dump_last),  32'd0);
        chk("rst_addr",  32'(if0.dump_addr),  32'd0);
        chk("rst_data",  32'(if0.dump_data),  32'd0);
        chk("rst_valid_d2", 32'(if2.dump_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            src0 = 4'(i); src1 = 4'(15 - i);
            #1;
            chk("rst_outa", 32'(if0.outa), 32'd0);
            chk("rst_outb", 32'(if0.outb), 32'd0);
            chk("rst_outa_d1", 32'(if1.outa), 32'd0);
            step();
        end

        // basic write then read
        we = 1'b1; dst = 4'd3; data = 8'h5A;
        step();
        dst = 4'd15; data = 8'hA5;
        step();
        we = 1'b0; src0 = 4'd3; src1 = 4'd15;
        #1;
        chk("wr_outa_r3",  32'(if0.outa), 32'h5A);
        chk("wr_outb_r15", 32'(if0.outb), 32'hA5);
        chk("wr_outa_r3_d1", 32'(if1.outa), 32'h5A);
        step();

        // bypass: r7=11, then write 3C while reading r7
        we = 1'b1; dst = 4'd7; data = 8'h11;
        step();
        data = 8'h3C; src0 = 4'd7; src1 = 4'd7;
        #1;
        chk("byp_outa",    32'(if0.outa), 32'h3C);
        chk("byp_outb",    32'(if0.outb), 32'h3C);
        chk("nobyp_outa",  32'(if1.outa), 32'h11);
        chk("nobyp_outb",  32'(if1.outb), 32'h11);
        step();
        we = 1'b0;
        #1;
        chk("nobyp_outa_next", 32'(if1.outa), 32'h3C);
        chk("nobyp_outb_next", 32'(if1.outb), 32'h3C);
        chk("byp_outa_next",   32'(if0.outa), 32'h3C);
        step();

        // r0..r8 = 1..9
        for (int i = 0; i < 9; i++) begin
            we = 1'b1; dst = 4'(i); data = 8'(i + 1);
            step();
        end
        we = 1'b0;

        // full-rate dump
        dump_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int b = 0; b < 9; b++) begin
            chk("full_valid", 32'(if0.dump_valid), 32'd1);
            chk("full_busy",  32'(if0.dump_busy),  32'd1);
            chk("full_addr",  32'(if0.dump_addr),  32'(b));
            chk("full_data",  32'(if0.dump_data),  32'(b + 1));
            chk("full_last",  32'(if0.dump_last),  32'(b == 8));
            chk("full_data_d1", 32'(if1.dump_data), 32'(b + 1));
            step();
        end
        chk("full_end_valid", 32'(if0.dump_valid), 32'd0);
        chk("full_end_busy",  32'(if0.dump_busy),  32'd0);
        chk("full_end_last",  32'(if0.dump_last),  32'd0);

        // backpressure at beat addr 2, with r2 written during the stall
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("bp_addr0", 32'(if0.dump_addr), 32'd0);
        step();
        chk("bp_addr1", 32'(if0.dump_addr), 32'd1);
        step();
        dump_ready = 1'b0;
        chk("bp_addr2", 32'(if0.dump_addr), 32'd2);
        chk("bp_data2", 32'(if0.dump_data), 32'd3);
        we = 1'b1; dst = 4'd2; data = 8'hFF;
        step();
        we = 1'b0;
        chk("bp_hold_valid", 32'(if0.dump_valid), 32'd1);
        chk("bp_hold_addr",  32'(if0.dump_addr),  32'd2);
        chk("bp_hold_data",  32'(if0.dump_data),  32'd3);
        chk("bp_hold_last",  32'(if0.dump_last),  32'd0);
        step();
        chk("bp_hold2_addr", 32'(if0.dump_addr), 32'd2);
        chk("bp_hold2_data", 32'(if0.dump_data), 32'd3);
        dump_ready = 1'b1;
        step();
        chk("bp_addr3", 32'(if0.dump_addr), 32'd3);
        chk("bp_data3", 32'(if0.dump_data), 32'd4);
        for (int b = 4; b < 9; b++) begin
            step();
            chk("bp_addr", 32'(if0.dump_addr), 32'(b));
            chk("bp_data", 32'(if0.dump_data), 32'(b + 1));
            chk("bp_last", 32'(if0.dump_last), 32'(b == 8));
        end
        step();
        chk("bp_end_busy", 32'(if0.dump_busy), 32'd0);
        step();

        // wrapping window 14,15,0,1 with r14 written on the start edge
        we = 1'b1; dst = 4'd15; data = 8'hF0;
        step();
        dst = 4'd14; data = 8'hEE; dump_start = 1'b1;
        step();
        we = 1'b0; dump_start = 1'b0;
        chk("wrap_valid0", 32'(if2.dump_valid), 32'd1);
        chk("wrap_addr0",  32'(if2.dump_addr),  32'd14);
        chk("wrap_data0",  32'(if2.dump_data),  32'hEE);
        chk("wrap_last0",  32'(if2.dump_last),  32'd0);
        chk("d0_beat0_data", 32'(if0.dump_data), 32'd1);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("wrap_addr1", 32'(if2.dump_addr), 32'd15);
        chk("wrap_data1", 32'(if2.dump_data), 32'hF0);
        chk("wrap_last1", 32'(if2.dump_last), 32'd0);
        step();
        chk("wrap_addr2", 32'(if2.dump_addr), 32'd0);
        chk("wrap_data2", 32'(if2.dump_data), 32'd1);
        chk("wrap_last2", 32'(if2.dump_last), 32'd0);
        step();
        chk("wrap_addr3", 32'(if2.dump_addr), 32'd1);
        chk("wrap_data3", 32'(if2.dump_data), 32'd2);
        chk("wrap_last3", 32'(if2.dump_last), 32'd1);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        chk("wrap_end_valid", 32'(if2.dump_valid), 32'd0);
        chk("wrap_end_busy",  32'(if2.dump_busy),  32'd0);
        chk("wrap_end_last",  32'(if2.dump_last),  32'd0);

        // d0 started with d2 and ignored both extra starts: now at beat 4
        chk("mid_valid", 32'(if0.dump_valid), 32'd1);
        chk("mid_addr",  32'(if0.dump_addr),  32'd4);
        chk("mid_data",  32'(if0.dump_data),  32'd5);

        // reset mid-dump
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_valid", 32'(if0.dump_valid), 32'd0);
        chk("mrst_busy",  32'(if0.dump_busy),  32'd0);
        chk("mrst_last",  32'(if0.dump_last),  32'd0);
        chk("mrst_addr",  32'(if0.dump_addr),  32'd0);
        chk("mrst_data",  32'(if0.dump_data),  32'd0);
        for (int i = 0; i < 16; i++) begin
            src0 = 4'(i); src1 = 4'(15 - i);
            #1;
            chk("mrst_outa", 32'(if0.outa), 32'd0);
            chk("mrst_outb", 32'(if0.outb), 32'd0);
            step();
        end

        // fresh dump after reset streams zeros
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int b = 0; b < 9; b++) begin
            chk("zero_valid", 32'(if0.dump_valid), 32'd1);
            chk("zero_addr",  32'(if0.dump_addr),  32'(b));
            chk("zero_data",  32'(if0.dump_data),  32'd0);
            chk("zero_last",  32'(if0.dump_last),  32'(b == 8));
            step();
        end
        chk("zero_end_busy", 32'(if0.dump_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_stream.md
Name: regfile_stream

Overview:
Parametrised successor to the 8-bit, 16-entry puzzle register file. It keeps two asynchronous read ports and one synchronous write port. It adds optional write-to-read bypass and a dump engine. The dump engine streams a contiguous window of registers (default: the 9 board cells) to memory over a valid/ready handshake. It sits between the datapath (src/dst/data) and the memory-write block.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read stored value only
DUMP_BASE, 0, first register index streamed by a dump
DUMP_COUNT, 9, number of registers per dump; legal range 1..DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
src0  in  ADDR_W  read address A
src1  in  ADDR_W  read address B
dst  in  ADDR_W  write address
we  in  1  write enable
data  in  DATA_W  write data
outa  out  DATA_W  read data A (combinational)
outb  out  DATA_W  read data B (combinational)
dump_start  in  1  single-cycle request to begin a dump
dump_busy  out  1  dump in progress
dump_valid  out  1  dump beat valid
dump_ready  in  1  sink accepts beat
dump_addr  out  ADDR_W  register index of current beat
dump_data  out  DATA_W  register value of current beat
dump_last  out  1  current beat is final beat of dump

Behaviour:
- Reset: rst_n sampled low at a rising edge.
  - All DEPTH registers are cleared to 0.
  - FSM goes to IDLE.
  - dump_busy, dump_valid, dump_last, dump_addr and dump_data all go to 0.
  - Reset mid-dump aborts the dump with no further beats; the sink must discard the partial stream.
- Write: when we=1, regis[dst] <= data at the edge. When we=0 every register holds its value. Writes are never blocked by a dump.
- Read:
  - outa = regis[src0] and outb = regis[src1], combinational.
  - If BYPASS=1 and we=1 and src0==dst, outa = data in the same cycle. The same rule applies to outb with src1.
  - If BYPASS=0 the new value appears on the read port the cycle after the write.
- FSM states: IDLE, SEND.
- IDLE:
  - dump_start=1 at an edge -> SEND; index i <= 0; dump_busy <= 1; dump_valid <= 1.
  - dump_data is loaded with the post-edge content of reg[DUMP_BASE]. A write to that register on the same edge is captured (forwarded).
  - dump_last <= (DUMP_COUNT==1).
- SEND, dump_valid && !dump_ready: dump_addr, dump_data and dump_last are held stable. This holds even if the source register is written meanwhile; each beat is a snapshot taken at load time.
- SEND, handshake (dump_valid && dump_ready at an edge):
  - If dump_last: -> IDLE; dump_valid, dump_busy and dump_last go to 0 after that edge.
  - Otherwise: i <= i+1; the next beat is loaded at the same edge from reg[(DUMP_BASE+i+1) mod DEPTH] (post-edge value, forwarded); dump_last <= (i+1 == DUMP_COUNT-1).
  - With continuous ready, throughput is 1 beat per cycle and a dump takes DUMP_COUNT cycles.
- Address arithmetic: dump_addr = (DUMP_BASE + i) mod DEPTH, so a window wraps from DEPTH-1 to 0.
- dump_start while dump_busy=1 (including the final handshake cycle) is ignored; it is not queued.
- dump_ready while dump_valid=0 has no effect.
- Latency: dump_start at edge k -> first beat valid in the cycle after edge k.

Test Plan:
- Reset/basic write-read: drive reset, then write 8'h5A to r3 and 8'hA5 to r15 -> every register reads 0 before the writes; after the writes outa(src0=3)=5A and outb(src1=15)=A5.
- Bypass: BYPASS=1, we=1, dst=7, data=8'h3C, src0=src1=7, r7 holding 8'h11 -> outa=outb=3C in the same cycle. With BYPASS=0 -> 11 that cycle, 3C the next.
- Full-rate dump: r0..r8 = 1..9, dump_ready tied 1, pulse dump_start -> 9 consecutive beats with addr 0..8, data 1..9; dump_last only on addr 8; dump_busy low the cycle after.
- Backpressure plus write during stall: stall with dump_ready=0 at beat addr 2 (data 3) and write r2=8'hFF during the stall -> beat stays addr 2 / data 3 until accepted; beat addr 3 follows.
- Wrap and reject: DUMP_BASE=14, DUMP_COUNT=4 -> addresses 14, 15, 0, 1. A second dump_start mid-dump produces no extra beats.
- Reset mid-dump: assert rst_n=0 at beat 4 -> next cycle dump_valid=0, dump_busy=0, all registers 0. A fresh dump then streams all zeros.
